// File: rtl/decode_issue_stage_pkg.sv
// Shared widths and forwarding-select encodings for the ID->EX boundary.
package decode_issue_stage_pkg;

    localparam int unsigned DataBusBits    = 64;
    localparam int unsigned RegAddrBits    = 5;
    localparam int unsigned ForwardSelBits = 2;

    typedef enum logic [ForwardSelBits-1:0] {
        FWD_RF   = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_t;

endpackage

// File: rtl/decode_issue_stage_forward_mux.sv
// Per-source operand selection: x0, EX forward, MEM forward, else register file.
module forward_mux
    import decode_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataBusBits,
    parameter int unsigned REG_W  = RegAddrBits
) (
    input  logic [REG_W-1:0]  src,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] operand
);

    fwd_sel_t sel;

    // A load in EX has no data yet; that case is covered by the load-use stall.
    always_comb begin
        sel = FWD_RF;
        if (src == '0)
            sel = FWD_ZERO;
        else if (ex_valid && ex_we && !ex_is_load && (ex_rd == src))
            sel = FWD_EX;
        else if (mem_valid && mem_we && (mem_rd == src))
            sel = FWD_MEM;
    end

    always_comb begin
        operand = rf_rdata;
        case (sel)
            FWD_ZERO: operand = '0;
            FWD_EX:   operand = ex_result;
            FWD_MEM:  operand = mem_result;
            default:  operand = rf_rdata;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// ID->EX stage: operand forwarding, load-use hazard detection and the ID/EX register.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataBusBits,
    parameter int unsigned REG_W  = RegAddrBits
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] id_imm,
    output logic [REG_W-1:0]  rf_raddr1,
    output logic [REG_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_we,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_we,
    output logic              ex_is_load,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [31:0]       stall_count
);

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hz;

    assign rf_raddr1 = id_rs1;
    assign rf_raddr2 = id_rs2;

    forward_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd1 (
        .src        (id_rs1),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .rf_rdata   (rf_rdata1),
        .operand    (op1)
    );

    forward_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd2 (
        .src        (id_rs2),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .rf_rdata   (rf_rdata2),
        .operand    (op2)
    );

    // rs2 is compared even for instructions that ignore it (conservative by design).
    always_comb begin
        hz = id_valid && ex_valid && ex_is_load && ex_we && (ex_rd != '0)
             && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        stall = hz && !flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_we       <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            stall_count <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_we      <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (hz) begin
            ex_valid   <= 1'b0;
            ex_we      <= 1'b0;
            ex_is_load <= 1'b0;
            if (stall_count != '1)
                stall_count <= stall_count + 32'd1;
        end else begin
            ex_valid   <= id_valid;
            ex_rd      <= id_rd;
            ex_we      <= id_we && id_valid;
            ex_is_load <= id_is_load && id_valid;
            ex_op1     <= op1;
            ex_op2     <= op2;
            ex_imm     <= id_imm;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural ID/EX model.
module tb_decode_issue_stage;

    localparam int DW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_we, id_is_load;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] rf_raddr1, rf_raddr2;
    logic [DW-1:0] rf_rdata1, rf_rdata2;
    logic [DW-1:0] ex_result;
    logic [RW-1:0] mem_rd;
    logic          mem_we, mem_valid;
    logic [DW-1:0] mem_result;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [RW-1:0] ex_rd;
    logic          ex_we, ex_is_load;
    logic [DW-1:0] ex_op1, ex_op2, ex_imm;
    logic [31:0]   stall_count;

    decode_issue_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_we(id_we), .id_is_load(id_is_load), .id_imm(id_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_valid(mem_valid), .mem_result(mem_result), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit [RW-1:0] rd;
        bit          we;
        bit          load;
        bit [DW-1:0] op1;
        bit [DW-1:0] op2;
        bit [DW-1:0] imm;
    } idex_t;

    idex_t     m;
    bit [31:0] mcnt;
    int        n_checks = 0;
    int        n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit [DW-1:0] pick(input bit [RW-1:0] s, input bit [DW-1:0] rf);
        if (s == 0) return '0;
        if (m.valid && m.we && !m.load && m.rd == s) return ex_result;
        if (mem_valid && mem_we && mem_rd == s) return mem_result;
        return rf;
    endfunction

    function automatic bit model_hz();
        return id_valid && m.valid && m.load && m.we && m.rd != 0
               && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic model_reset();
        m = '{valid: 1'b0, rd: '0, we: 1'b0, load: 1'b0, op1: '0, op2: '0, imm: '0};
        mcnt = 0;
    endtask

    task automatic check_outputs();
        check("ex_valid",    ex_valid,    m.valid);
        check("ex_rd",       ex_rd,       m.rd);
        check("ex_we",       ex_we,       m.we);
        check("ex_is_load",  ex_is_load,  m.load);
        check("ex_op1",      ex_op1,      m.op1);
        check("ex_op2",      ex_op2,      m.op2);
        check("ex_imm",      ex_imm,      m.imm);
        check("stall_count", stall_count, mcnt);
    endtask

    // Inputs are already applied; checks combinational outputs, clocks once, checks the register.
    task automatic step();
        idex_t nx;
        bit    hz;
        #1;
        hz = model_hz();
        check("stall", stall, hz && !flush);
        check("rf_raddr1", rf_raddr1, id_rs1);
        check("rf_raddr2", rf_raddr2, id_rs2);
        nx = m;
        if (flush || hz) begin
            nx.valid = 0; nx.we = 0; nx.load = 0;
            if (!flush && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        end else begin
            nx.valid = id_valid;
            nx.rd    = id_rd;
            nx.we    = id_we && id_valid;
            nx.load  = id_is_load && id_valid;
            nx.op1   = pick(id_rs1, rf_rdata1);
            nx.op2   = pick(id_rs2, rf_rdata2);
            nx.imm   = id_imm;
        end
        @(posedge clk);
        #1;
        m = nx;
        check_outputs();
    endtask

    task automatic quiet();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_we = 0; id_is_load = 0;
        id_imm = '0; rf_rdata1 = '0; rf_rdata2 = '0; ex_result = '0;
        mem_rd = 0; mem_we = 0; mem_valid = 0; mem_result = '0; flush = 0;
    endtask

    task automatic issue(input bit [RW-1:0] rd, input bit we, input bit load,
                         input bit [RW-1:0] rs1, input bit [RW-1:0] rs2);
        id_valid = 1; id_rd = rd; id_we = we; id_is_load = load;
        id_rs1 = rs1; id_rs2 = rs2;
    endtask

    initial begin
        bit [31:0] cnt_before;
        quiet();
        model_reset();
        reset = 0;
        #12;
        check_outputs();
        check("stall_rst", stall, 1'b0);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;

        // EX forwarding: ADD x5 then a consumer of x5
        quiet(); issue(5, 1, 0, 1, 2); step();
        quiet(); issue(6, 1, 0, 5, 0); ex_result = 64'h11; rf_rdata1 = 64'h99; step();
        check("ex_fwd", ex_op1, 64'h11);

        // EX beats MEM on the same register, MEM used once EX stops writing
        quiet(); issue(7, 1, 0, 0, 0); step();
        quiet(); issue(8, 1, 0, 0, 7); ex_result = 64'hAA; mem_valid = 1; mem_we = 1;
        mem_rd = 7; mem_result = 64'hBB; rf_rdata2 = 64'hCC; step();
        check("prio_ex", ex_op2, 64'hAA);
        quiet(); issue(7, 0, 0, 0, 0); step();
        quiet(); issue(8, 1, 0, 0, 7); ex_result = 64'hAA; mem_valid = 1; mem_we = 1;
        mem_rd = 7; mem_result = 64'hBB; rf_rdata2 = 64'hCC; step();
        check("prio_mem", ex_op2, 64'hBB);

        // Load-use: one stall cycle, bubble, then re-issue forwarded from MEM
        quiet(); issue(3, 1, 1, 0, 0); step();
        cnt_before = stall_count;
        quiet(); issue(4, 1, 0, 3, 9); rf_rdata1 = 64'h77; step();
        check("lu_bubble", ex_valid, 1'b0);
        check("lu_count", stall_count, cnt_before + 1);
        mem_valid = 1; mem_we = 1; mem_rd = 3; mem_result = 64'h1234;
        #1;
        check("lu_one_cycle", stall, 1'b0);
        step();
        check("lu_reissue_op", ex_op1, 64'h1234);
        check("lu_reissue_v", ex_valid, 1'b1);

        // x0 is never forwarded, and a load to x0 raises no hazard
        quiet(); issue(0, 1, 0, 0, 0); step();
        quiet(); issue(9, 1, 0, 0, 0); ex_result = 64'hFF; rf_rdata1 = 64'h5; step();
        check("x0_op", ex_op1, 64'h0);
        quiet(); issue(0, 1, 1, 0, 0); step();
        quiet(); issue(9, 1, 0, 0, 0);
        #1;
        check("x0_nostall", stall, 1'b0);
        step();

        // Flush wins over a load-use hazard
        quiet(); issue(3, 1, 1, 0, 0); step();
        cnt_before = stall_count;
        quiet(); issue(4, 1, 0, 3, 0); flush = 1; step();
        check("flush_valid", ex_valid, 1'b0);
        check("flush_count", stall_count, cnt_before);

        // Asynchronous reset while stalling
        quiet(); issue(3, 1, 1, 0, 0); step();
        quiet(); issue(4, 1, 0, 0, 3);
        #1;
        check("pre_rst_stall", stall, 1'b1);
        reset = 0;
        #1;
        model_reset();
        check("rst_stall", stall, 1'b0);
        check_outputs();
        @(negedge clk);
        reset = 1;
        quiet();
        @(posedge clk);
        #1;

        // Counter saturation
        force dut.stall_count = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count;
        mcnt = 32'hFFFF_FFFF;
        quiet(); issue(3, 1, 1, 0, 0); step();
        quiet(); issue(4, 1, 0, 3, 0); step();
        check("sat_count", stall_count, 32'hFFFF_FFFF);

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = RW'($urandom_range(0, 7));
            id_rs2     = RW'($urandom_range(0, 7));
            id_rd      = RW'($urandom_range(0, 7));
            id_we      = $urandom_range(0, 1) == 1;
            id_is_load = ($urandom_range(0, 2) == 0);
            id_imm     = {$urandom, $urandom};
            rf_rdata1  = {$urandom, $urandom};
            rf_rdata2  = {$urandom, $urandom};
            ex_result  = {$urandom, $urandom};
            mem_rd     = RW'($urandom_range(0, 7));
            mem_we     = $urandom_range(0, 1) == 1;
            mem_valid  = $urandom_range(0, 1) == 1;
            mem_result = {$urandom, $urandom};
            flush      = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- ID→EX boundary of the pipelined core.
- Sends source addresses to the register file and takes its combinational read data.
- Resolves RAW hazards by forwarding from EX and MEM, and detects load-use hazards (stall plus bubble).
- Registers resolved operands and control into the ID/EX pipeline register consumed by the EX stage.

Parameters:
- DATA_W, 64, datapath width (equals `DataBusBits in diagv2_const.vh).
- REG_W, 5, register address width (equals `RegAddrBits).

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- id_valid  in  1  a decoded instruction is present in ID.
- id_rs1, id_rs2  in  REG_W  source register addresses.
- id_rd  in  REG_W  destination register address.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_imm  in  DATA_W  sign-extended immediate.
- rf_raddr1, rf_raddr2  out  REG_W  equal to id_rs1 and id_rs2, combinational.
- rf_rdata1, rf_rdata2  in  DATA_W  register-file read data.
- ex_result  in  DATA_W  ALU result of the instruction held in ID/EX.
- mem_rd  in  REG_W  destination register of the MEM-stage instruction.
- mem_we  in  1  MEM-stage instruction writes rd.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_result  in  DATA_W  final MEM-stage value (load data or ALU result).
- flush  in  1  redirect; kill the instruction in ID.
- stall  out  1  hold IF and ID this cycle, combinational.
- ex_valid, ex_rd, ex_we, ex_is_load  out  1/REG_W/1/1  ID/EX control.
- ex_op1, ex_op2, ex_imm  out  DATA_W  ID/EX data.
- stall_count  out  32  saturating count of load-use stall cycles.

Behaviour:
- Operand select, per source s, first match wins:
  - s == 0 → 0.
  - ex_valid && ex_we && !ex_is_load && ex_rd == s → ex_result.
  - mem_valid && mem_we && mem_rd == s → mem_result.
  - otherwise → rf_rdata.
- The register file writes on negedge, so WB-stage values are already visible on rf_rdata in the second half-cycle. No WB forwarding.
- Load-use hazard: `hz = id_valid && ex_valid && ex_is_load && ex_we && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)`.
- A hazard is raised even when the instruction does not actually use rs2. This conservative behaviour is the required one.
- `stall = hz && !flush`.
- Rising edge, in priority order:
  - reset low → all outputs cleared, including stall_count.
  - flush → ex_valid=0; ex_we=0; ex_is_load=0; data registers unchanged.
  - hz → bubble, same as flush; stall_count += 1, saturating at 0xFFFF_FFFF.
  - otherwise → capture id_valid, the selected operands, id_imm, id_rd, id_we, id_is_load.
- ex_we and ex_is_load are gated with id_valid when captured.
- Latency: one cycle from ID to EX.
- A stalled instruction re-issues on the cycle after the bubble, taking forwarding from MEM, where the load now sits.
- flush and hz in the same cycle: flush wins, stall=0, counter not incremented.
- Reset asserted mid-stall: asynchronous clear; stall drops immediately because ex_valid=0.
- Reset release: synchronous to clk (two-flop synchronizer lives outside the block).
- id_rd == 0 with id_we=1: captured as-is. Consumers never forward x0 because of the s == 0 rule.

Decomposition:
- Shared constants stay in diagv2_const.vh: `DataBusBits, `RegAddrBits, `RegZero, `DataZero.
- Add `ForwardSelBits and encodings FWD_RF, FWD_EX, FWD_MEM, FWD_ZERO.
- One sub-module: forward_mux.
  - Combinational; instantiated twice, once per source.
  - Inputs: source address, EX/MEM tags and data, rf data.
  - Output: operand.
- Hazard logic, pipeline register and counter stay in the top.

Test Plan:
- EX forwarding:
  - ID/EX holds ADD x5 (ex_result=0x11).
  - Next: id_rs1=5, rf_rdata1=0x99.
  - → ex_op1=0x11 after the edge.
- Priority:
  - ex_rd=mem_rd=7, ex_result=0xAA, mem_result=0xBB, id_rs2=7.
  - → ex_op2=0xAA.
  - Drop ex_we → ex_op2=0xBB.
- Load-use:
  - ID/EX holds LD x3; id_rs1=3.
  - → stall=1 for exactly one cycle; ex_valid=0 bubble; stall_count=1.
  - Next cycle: mem_rd=3, mem_result=0x1234 → ex_op1=0x1234, ex_valid=1.
- x0:
  - id_rs1=0, ex_rd=0, ex_we=1, ex_result=0xFF, rf_rdata1=0x5.
  - → ex_op1=0.
  - With a load to x0 in EX → no stall.
- Flush vs stall:
  - Load-use condition with flush=1.
  - → stall=0, ex_valid=0, stall_count unchanged.
- Reset and saturation:
  - Drive reset=0 asynchronously mid-stall.
  - → all outputs 0 before the next edge.
  - Preload the counter to 0xFFFF_FFFF, then force a hazard → count stays 0xFFFF_FFFF.
